bus_alu: RTL
============

Name: bus_alu

Overview:
- Execution unit sitting directly downstream of the general-purpose registers.
- Consumes the A-bus and B-bus operands those registers drive, and produces the C-bus result.
- `c_valid` is the one-cycle write strobe that the sequencer routes to the destination register's `latch` input.
- Logic ops and add/sub complete in one cycle. Multiply is a multi-cycle shift-add sequence with busy/done handshake, so the bus operands only have to be stable in the start cycle.

Parameters:
- DATA_W, 16: operand/result width; must equal the codebase-wide bus width (`DATA_W`).
- CNT_W, 5: iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- a  input  DATA_W  A-bus operand.
- b  input  DATA_W  B-bus operand.
- op  input  3  operation select, sampled with start.
- start  input  1  request; accepted only in IDLE.
- c  output  DATA_W  C-bus result, registered.
- c_valid  output  1  one-cycle pulse: c holds a new result; drives destination latch.
- busy  output  1  high while a multiply is in progress.
- zero  output  1  result flag, registered with c.
- carry  output  1  carry/borrow/overflow flag, registered with c.

Behaviour:
- Reset (rst_n=0 at a rising edge, any state, including mid-multiply):
  - FSM goes to IDLE; c, c_valid, busy, zero, carry all become 0.
  - Counter and internal accumulators clear; any in-flight multiply is discarded with no c_valid.
- Op encoding (all arithmetic unsigned, modulo 2**DATA_W):
  - 000 ADD: c = a+b; carry = carry-out.
  - 001 SUB: c = a-b; carry = borrow (a<b).
  - 010 AND; 011 OR; 100 XOR: carry = 0.
  - 101 PASS: c = a; carry = 0.
  - 110 NOT: c = ~a; carry = 0.
  - 111 MUL: c = low DATA_W bits of a*b; carry = 1 if the high half of the full 2*DATA_W product is nonzero.
  - zero = (c == 0) for every op.
- FSM states: IDLE, MUL.
- IDLE:
  - start=1, op != 111 (cycle k): result, zero and carry register at the end of cycle k. c_valid=1 in cycle k+1 only. Stay in IDLE.
  - Back-to-back single-cycle ops are accepted every cycle, giving consecutive c_valid pulses.
  - start=1, op=111 (cycle k): capture multiplicand=a, multiplier=b; clear the 2*DATA_W accumulator and counter; go to MUL. busy=1 from cycle k+1.
  - start=0: hold c, zero and carry; c_valid=0.
- MUL, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand (2*DATA_W wide, multiplicand zero-extended).
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - The step that brings the counter to DATA_W (end of cycle k+DATA_W) registers c, zero and carry from the final accumulator and returns to IDLE.
  - Result: busy high in cycles k+1..k+DATA_W; c_valid=1 and busy=0 in cycle k+DATA_W+1.
- start while busy=1 is ignored: no capture, no effect on the running multiply, no queued request.
- start in the same cycle as c_valid is high is a legal IDLE request and is accepted.
- a, b and op are don't-care except in the cycle start is accepted; changes during MUL must not affect the result.
- c, zero and carry hold their last value between c_valid pulses and are never tri-stated by this block.
- No early termination: multiply always takes exactly DATA_W cycles, including operand 0.

Test Plan (DATA_W=16):
- Reset then idle: rst_n=0 for 2 cycles, then start=0 → c=0x0000, c_valid=0, busy=0, zero=0, carry=0.
- ADD overflow: a=0xFFFF, b=0x0001, op=000, start=1 one cycle → next cycle c_valid=1, c=0x0000, zero=1, carry=1; following cycle c_valid=0, c holds.
- Back-to-back singles:
  - Cycle k: SUB a=0x0003, b=0x0005.
  - Cycle k+1: XOR a=0x00F0, b=0x0FF0.
  - Response: c_valid in k+1 with c=0xFFFE, carry=1; c_valid in k+2 with c=0x0F00, carry=0.
- MUL timing plus input/start robustness:
  - a=0x0012, b=0x0034, op=111 at cycle k.
  - During busy, drive a/b random and pulse start with op=000.
  - Response: busy=1 for cycles k+1..k+16; c_valid=1 only at k+17 with c=0x03A8, carry=0, zero=0; the ignored start produces no extra c_valid.
- MUL overflow / zero: 0x1000*0x0010 → c=0x0000, zero=1, carry=1 at k+17. 0x0000*0xFFFF → c=0x0000, zero=1, carry=0, still 16 busy cycles.
- Reset mid-multiply: start MUL, assert rst_n=0 at cycle k+8 → busy=0 and c=0 next cycle, no c_valid ever. A new ADD 0x0002+0x0003 after release yields c=0x0005 in 1 cycle.

Source files
------------

// File: rtl/bus_alu.sv
// bus_alu: C-bus execution unit with single-cycle logic/add/sub ops and a shift-add multiplier
module bus_alu #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              start,
  output logic [DATA_W-1:0] c,
  output logic              c_valid,
  output logic              busy,
  output logic              zero,
  output logic              carry
);
  typedef enum logic {IDLE, MUL} state_t;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_XOR = 3'b100, OP_PASS = 3'b101, OP_NOT = 3'b110, OP_MUL = 3'b111;
  state_t              state, state_nx;
  logic [2*DATA_W-1:0] mcand, acc, acc_nx;
  logic [DATA_W-1:0]   mplier, res;
  logic [DATA_W:0]     sum, diff;
  logic [CNT_W-1:0]    cnt;
  logic                res_cy, last_step;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign acc_nx    = acc + (mplier[0] ? mcand : '0);
  assign last_step = cnt == CNT_W'(DATA_W - 1);
  assign busy      = state == MUL;
  always_comb begin
    res    = '0;
    res_cy = 1'b0;
    case (op)
      OP_ADD:  {res_cy, res} = sum;
      OP_SUB:  {res_cy, res} = diff;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_PASS: res = a;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((start && op == OP_MUL) ? MUL : IDLE) : (last_step ? IDLE : MUL);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      c       <= '0;
      c_valid <= 1'b0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      c_valid <= 1'b0;
      if (state == IDLE && start && op == OP_MUL) begin
        mcand  <= {{DATA_W{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == IDLE && start) begin
        c       <= res;
        zero    <= res == '0;
        carry   <= res_cy;
        c_valid <= 1'b1;
      end
      if (state == MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last_step) begin
          c       <= acc_nx[DATA_W-1:0];
          zero    <= acc_nx[DATA_W-1:0] == '0;
          carry   <= |acc_nx[2*DATA_W-1:DATA_W];
          c_valid <= 1'b1;
        end
      end
    end
  end
endmodule
